// File: rtl/divide_unit_pkg.sv
// Shared constants for the EX-stage divider: ALU divide opcodes, FSM encoding and datapath width.
package divide_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_DIVU = 5'b01101;
  localparam logic [4:0] OP_REM  = 5'b01110;
  localparam logic [4:0] OP_REMU = 5'b01111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  // The four divide opcodes are exactly the 011xx block of the decoder's ALU space.
  function automatic logic is_div_op(input logic [4:0] op);
    return (op[4:2] == 3'b011);
  endfunction

endpackage

// File: rtl/divide_unit_div_step.sv
// One combinational radix-2 restoring iteration: shift {rem,quo} left, trial-subtract, keep if non-negative.
module divide_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor always holds, so the trial fits in XLEN+1 bits and its MSB is the sign.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_out = shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divide_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; holds busy high so the pipeline stalls
// until the one-cycle done pulse delivers the result.
module divide_unit
  import divide_unit_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      alu_opcode,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic              signed_op;
  logic              rem_sel;
  logic              a_neg;
  logic              q_neg;
  logic              special;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   div_q;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   quo_nx;

  logic              op_signed;
  logic              in_a_neg;
  logic              in_b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              b_zero;
  logic              overflow;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  divide_unit_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Opcode bit 0 clear means a signed op; bit 1 set selects the remainder.
  assign op_signed = ~alu_opcode[0];
  assign in_a_neg  = op_signed & operand_a[XLEN-1];
  assign in_b_neg  = op_signed & operand_b[XLEN-1];
  assign abs_a     = in_a_neg ? (~operand_a + 1'b1) : operand_a;
  assign abs_b     = in_b_neg ? (~operand_b + 1'b1) : operand_b;
  assign b_zero    = (operand_b == '0);
  assign overflow  = op_signed && (operand_a == INT_MIN) && (operand_b == '1);

  assign quo_fix = (signed_op && q_neg) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = (signed_op && a_neg) ? (~rem_q + 1'b1) : rem_q;

  // Single FSM with registered busy/done/result; flush overrides everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      signed_op <= 1'b0;
      rem_sel   <= 1'b0;
      a_neg     <= 1'b0;
      q_neg     <= 1'b0;
      special   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !done && is_div_op(alu_opcode)) begin
              signed_op <= op_signed;
              rem_sel   <= alu_opcode[1];
              a_neg     <= in_a_neg;
              q_neg     <= in_a_neg ^ in_b_neg;
              cnt       <= '0;
              busy      <= 1'b1;
              if (b_zero) begin
                special <= 1'b1;
                quo_q   <= '1;
                rem_q   <= operand_a;
                div_q   <= '0;
                state   <= FINISH;
              end else if (overflow) begin
                special <= 1'b1;
                quo_q   <= INT_MIN;
                rem_q   <= '0;
                div_q   <= operand_b;
                state   <= FINISH;
              end else begin
                special <= 1'b0;
                quo_q   <= abs_a;
                rem_q   <= '0;
                div_q   <= abs_b;
                state   <= DIVIDE;
              end
            end
          end
          DIVIDE: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
              state <= FINISH;
            end
          end
          FINISH: begin
            if (special) begin
              result <= rem_sel ? rem_q : quo_q;
            end else begin
              result <= rem_sel ? rem_fix : quo_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed self-checking bench for divide_unit: signed/unsigned results, fast paths, latency,
// flush, ignored starts and asynchronous reset.
module tb_divide_unit;
  import divide_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  alu_opcode = 5'b0;
  logic [31:0] operand_a = 32'h0;
  logic [31:0] operand_b = 32'h0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int assert_count = 0;
  int fail_count = 0;
  int lat;
  int busy_cycles;
  int done_seen;

  always #5 clk = ~clk;

  divide_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_opcode (alu_opcode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one start cycle, then scrambles the operands to prove they were captured.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_opcode = op; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; alu_opcode = 5'b0; operand_a = 32'hDEADBEEF; operand_b = 32'h0000_0003;
  endtask

  task automatic waitDone(input int first, output int n, output int b_cnt);
    n = first;
    b_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) b_cnt++;
    end
  endtask

  task automatic countDones(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
  endtask

  task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_result, input int exp_lat,
                       input int exp_busy);
    int n;
    int bc;
    applyStimulus(op, a, b);
    waitDone(1, n, bc);
    checkOutput({tag, "_result"}, result, exp_result);
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_busy_cycles"}, bc, exp_busy);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    $display("[TB] divide_unit directed test start");

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    runOp("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33);
    runOp("rem_m7_2",     OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33);
    runOp("divu_max_2",   OP_DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 34, 33);
    runOp("remu_max_2",   OP_REMU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 34, 33);
    runOp("div_5_0",      OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 2, 1);
    runOp("rem_5_0",      OP_REM,  32'd5,        32'd0,        32'h00000005, 2, 1);
    runOp("divu_min_0",   OP_DIVU, 32'h80000000, 32'd0,        32'hFFFFFFFF, 2, 1);
    runOp("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1);
    runOp("rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1);
    runOp("rem_m7_m2",    OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 34, 33);
    runOp("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 33);
    runOp("rem_7_m2",     OP_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 34, 33);

    // Flush at iteration 10 of DIV 100/7
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_done", {31'b0, done}, 32'd0);
    checkOutput("flush_result_held", result, 32'h00000001);
    countDones(40, done_seen);
    checkOutput("flush_no_done", done_seen, 32'd0);
    runOp("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, 34, 33);

    // START while busy is dropped
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; alu_opcode = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0; alu_opcode = 5'b0;
    waitDone(3, lat, busy_cycles);
    checkOutput("busy_start_result", result, 32'd14);
    checkOutput("busy_start_latency", lat, 32'd34);
    // START coinciding with DONE is dropped too
    start = 1'b1; alu_opcode = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0; alu_opcode = 5'b0;
    checkOutput("start_on_done_busy", {31'b0, busy}, 32'd0);
    countDones(40, done_seen);
    checkOutput("busy_start_single_done", done_seen, 32'd0);

    // Non-divide opcode is ignored
    @(negedge clk);
    start = 1'b1; alu_opcode = 5'b00000; operand_a = 32'd9; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("bad_op_busy", {31'b0, busy}, 32'd0);
    countDones(40, done_seen);
    checkOutput("bad_op_no_done", done_seen, 32'd0);
    checkOutput("bad_op_result_held", result, 32'd14);

    // Asynchronous reset in the middle of DIVIDE
    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_reset_done", {31'b0, done}, 32'd0);
    checkOutput("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDones(40, done_seen);
    checkOutput("reset_no_done", done_seen, 32'd0);

    runOp("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/divide_unit.md
Name: divide_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage, directly downstream of the decoder.
- Consumes the decoder's 5-bit ALU opcode for DIV/DIVU/REM/REMU plus the two register operands, and produces a 32-bit result after a multi-cycle computation.
- Asserts BUSY so the hazard/stall logic can freeze IF/ID/EX while a divide is in flight.
- Single-cycle ALU operations never enter this block.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET_N  input  1  reset, asynchronous assert, active-low.
- START  input  1  request; sampled only in IDLE.
- ALU_OPCODE  input  5  01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU; any other value with START is ignored.
- OPERAND_A  input  XLEN  dividend (rs1).
- OPERAND_B  input  XLEN  divisor (rs2).
- FLUSH  input  1  abort the in-flight operation (branch/jump redirect).
- BUSY  output  1  operation in flight; drives the pipeline stall.
- DONE  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  XLEN  quotient or remainder, held until the next DONE.

Behaviour:
- Reset and clock: one clock; RESET_N is asynchronous and active-low. While RESET_N=0: state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal regs=0. A reset mid-operation discards the operation with no DONE.
- States: IDLE, DIVIDE, FINISH.
- IDLE:
  - START=1 with a divide opcode at edge k: latch signedness (DIV/REM signed), quotient/remainder select, sign of A, and sign of A XOR sign of B (quotient sign).
  - Load |A|, |B| (raw values for unsigned ops), partial remainder=0, counter=0. Go to DIVIDE, or to FINISH for special cases.
  - BUSY=1 from the cycle after edge k.
- Special cases go straight to FINISH (fast path):
  - B=0: quotient=all ones (0xFFFFFFFF), remainder=A. Applies to signed and unsigned ops.
  - Signed op, A=0x80000000, B=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- DIVIDE, one iteration per cycle:
  - Shift {rem,quo} left 1.
  - Trial = rem - divisor, computed at XLEN+1 bits.
  - If trial is non-negative: rem=trial, quo LSB=1.
  - counter++; after 32 iterations (counter==XLEN-1 at the edge) go to FINISH.
- FINISH:
  - RESULT <= selected value with sign fix. Quotient is negated if the quotient sign is set (signed ops only). Remainder is negated if the dividend was negative (signed ops only).
  - Special-case values are written unmodified.
  - DONE=1 for exactly this cycle, BUSY=0 in this cycle, then return to IDLE.
- Latency: START at edge k gives DONE high in the cycle after edge k+33 on the normal path, and after edge k+1 on the fast path.
- START rules:
  - START while BUSY=1 or in FINISH is ignored; the operation is not queued.
  - START in the same cycle as DONE is ignored; upstream re-asserts it.
- FLUSH:
  - FLUSH=1 in any state: next state is IDLE, BUSY=0, no DONE, RESULT unchanged.
  - FLUSH has priority over START in the same cycle.
- Operands are captured at START; changes on OPERAND_A/B during BUSY have no effect.

Decomposition:
- Shared package (ALU op constants): DIV=5'b01100, DIVU=5'b01101, REM=5'b01110, REMU=5'b01111, the state encoding (IDLE=2'd0, DIVIDE=2'd1, FINISH=2'd2), and XLEN.
- One sub-module is natural: div_step, a combinational single restoring iteration taking {rem, quo, divisor} and returning {rem', quo'}. It is instantiated once inside the FSM datapath so it can be exhaustively checked on its own.

Test Plan:
- DIV A=0xFFFFFFF9 (-7), B=2 -> DONE after 34 cycles, RESULT=0xFFFFFFFD (-3); REM with the same operands -> RESULT=0xFFFFFFFF (-1); BUSY high for exactly 33 cycles.
- DIVU A=0xFFFFFFFF, B=2 -> RESULT=0x7FFFFFFF; REMU with the same operands -> RESULT=1.
- DIV A=5, B=0 -> DONE 2 cycles after START, RESULT=0xFFFFFFFF; REM -> RESULT=5; DIVU 0x80000000/0 -> RESULT=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> RESULT=0x80000000 via the fast path; REM -> RESULT=0.
- Start DIV 100/7, pulse FLUSH at iteration 10 -> BUSY=0 next cycle, no DONE, RESULT keeps its prior value; a new REM 100/7 then completes with RESULT=2.
- During BUSY, pulse START with DIVU 9/3, and separately assert START with ALU_OPCODE=00000 while IDLE -> both ignored; the original op yields a single DONE. Assert RESET_N=0 mid-DIVIDE -> outputs zero immediately (asynchronous), no DONE afterwards.
